s_alu_seq: RTL
==============

# s_alu_seq

Parametrised, clocked successor to the S-Machine combinational ALU. Executes one operation per `start` pulse on WIDTH-bit operands, holds results and a Z/N/C/V flag register internally, and adds multi-cycle barrel-free shifts (one bit per cycle) and a shift-add multiplier. Sits between the register file and writeback; the decoder maps instruction fields onto `op`/`imm`.

## Interface
- `WIDTH`, 16, operand/result width (≥ 4, power of two)
- `SHW`, $clog2(WIDTH), shift-amount width (derived, not overridden)
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset; one clock, synchronous, active-high
- `start`  in  1  request; sampled only when `busy`=0
- `op`  in  4  operation code (`s_alu_pkg::alu_op_t`)
- `imm`  in  8  immediate: INC addend, shift amount (`imm[SHW-1:0]`), SET/CLR mask (`imm[3:0]`={Z,N,C,V})
- `a_in`, `b_in`  in  WIDTH  operands, sampled with `start`
- `a_out`, `b_out`  out  WIDTH  registered results
- `z`, `n`, `c`, `v`  out  1  flag register
- `busy`  out  1  multi-cycle op in progress
- `done`  out  1  one-cycle pulse: results/flags updated this cycle

## Operation
- Ops: ADD, ADC (+c), SUB, SBB (−c), INC (a+zero-extended imm), AND, OR, XOR, CMP, SHL, SHR, ASR, MUL, MOV (b_out=a_in), EXCH, SET, CLR.
- Arithmetic results write `a_out`; CMP writes flags only; logical ops write `a_out`; unwritten outputs hold previous value.
- ADD/ADC/INC: C = carry-out of bit WIDTH-1; V = signed overflow.
- SUB/SBB/CMP: C = borrow (1 when a < b(+c) unsigned); V = signed overflow.
- Logical: C=0, V=0. Z = result==0, N = result[WIDTH-1] for all result-writing ops and CMP.
- Shifts: amount k=`imm[SHW-1:0]`; SHL/SHR fill 0, ASR fills sign; C = last bit shifted out; V unchanged. k=0: single-cycle, `a_out`=a_in, C unchanged, Z/N updated.
- MUL: unsigned a×b, product {b_out,a_out} (high,low); Z = full 2·WIDTH product ==0; N = product[2·WIDTH−1]; C=V= (high half ≠ 0).
- MOV/EXCH: flags unchanged. SET/CLR: set/clear flags per mask bits, data outputs unchanged.
- Unused op codes: no-op, `done` still pulses, nothing changes.
- FSM: IDLE → (single-cycle op) stays IDLE, writes results; IDLE → SHIFT (k≥1) loads a, counter=k; IDLE → MUL loads multiplicand, multiplier, acc=0, counter=WIDTH. SHIFT/MUL decrement counter each cycle; at counter==1 commit results, return to IDLE.

## Timing
- Reset: `a_out`=`b_out`=0, z=n=c=v=0, `busy`=0, `done`=0, state IDLE. Reset mid-operation aborts; no partial result committed.
- `start` sampled at edge t with `busy`=0. Single-cycle ops: outputs and `done`=1 valid in cycle t+1, `busy`=0.
- Shift k≥1: `busy`=1 cycles t+1..t+k; results and `done` in cycle t+k+1 (k is the count, latency k+1).
- MUL: `busy`=1 cycles t+1..t+WIDTH; results and `done` in cycle t+WIDTH+1.
- `start` during `busy` ignored (no queueing). `start` in a `done` cycle accepted (back-to-back).
- ADC/SBB use `c` as registered at sampling edge, including value just committed by previous op.
- Operand inputs may change freely after the sampling edge.

## Structure
- `s_alu_pkg`: `alu_op_t` enum (4-bit), flag-mask bit indices, FSM state enum.
- Sub-module `s_alu_addsub`: WIDTH-bit add/subtract with carry-in, carry/borrow-out and overflow; reused by ALU ops and the MUL accumulate step.
- Top holds FSM, counter (SHW+1 bits), shift/MUL datapath registers, flag register.

## Test plan
- WIDTH=16: ADD 0x7FFF+0x0001 → a_out=0x8000, N=1, V=1, C=0, Z=0, `done` at t+1.
- SUB 0x0003−0x0005 → a_out=0xFFFE, C=1, N=1; then SBB 0x0010−0x0001 → a_out=0x000E.
- SHR 0x8001 by k=3 → `busy` 3 cycles, a_out=0x1000, C=0, `done` at t+4; ASR 0x8000 k=15 → 0xFFFF; k=0 → one cycle, C unchanged.
- MUL 0xFFFF×0xFFFF → b_out=0xFFFE, a_out=0x0001, C=V=1, `done` at t+17; MUL 0×0x1234 → Z=1.
- `start` asserted during MUL busy → ignored; `start` in `done` cycle → accepted; `rst` at busy cycle 5 → all outputs 0 next cycle, no `done`.
- SET mask 0b1010 then CLR mask 0b1000 → z=0, n=0, c=1, v=0 after SET→CLR pair from reset; a_out/b_out unchanged.

Source files
------------

// File: rtl/s_alu_pkg.sv
// rtl/s_alu_pkg.sv - shared op codes, flag mask indices and FSM states for the sequential ALU
package s_alu_pkg;

  // Seventeen operations share sixteen codes: SET and CLR use one code, imm[4] picks clear.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADC  = 4'd1,
    OP_SUB  = 4'd2,
    OP_SBB  = 4'd3,
    OP_INC  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_CMP  = 4'd8,
    OP_SHL  = 4'd9,
    OP_SHR  = 4'd10,
    OP_ASR  = 4'd11,
    OP_MUL  = 4'd12,
    OP_MOV  = 4'd13,
    OP_EXCH = 4'd14,
    OP_FLG  = 4'd15
  } alu_op_t;

  localparam int FLAG_V   = 0;
  localparam int FLAG_C   = 1;
  localparam int FLAG_N   = 2;
  localparam int FLAG_Z   = 3;
  localparam int FLAG_CLR = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2
  } state_t;

endpackage

// File: rtl/s_alu_addsub.sv
// rtl/s_alu_addsub.sv - WIDTH-bit add/subtract with carry-in, carry/borrow-out and signed overflow
module s_alu_addsub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  logic [WIDTH-1:0] bx;
  logic             cin_x;
  logic             cy;

  // Subtract as a + ~b + ~borrow_in; carry-out is then inverted into a borrow.
  assign bx    = sub ? ~b : b;
  assign cin_x = sub ? ~cin : cin;
  assign {cy, sum} = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, cin_x};
  assign cout  = sub ? ~cy : cy;
  assign ovf   = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/s_alu_seq.sv
// rtl/s_alu_seq.sv - sequential S-Machine ALU with flag register, bit-serial shifts and shift-add multiply
module s_alu_seq
  import s_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  alu_op_t          op,
  input  logic [7:0]       imm,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v,
  output logic             busy,
  output logic             done
);
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(1);
  localparam logic [SHW:0] CNT_MUL  = (SHW+1)'(WIDTH);

  state_t           state;
  alu_op_t          sh_op;
  logic [SHW:0]     cnt;
  logic [WIDTH-1:0] sh_q, mcand, acc, mplr;

  logic [WIDTH-1:0] as_a, as_b, as_sum;
  logic             as_cin, as_sub, as_co, as_ov;
  logic [WIDTH-1:0] lg_res, sh_next, acc_next, mplr_next;
  logic             sh_out;
  logic [SHW-1:0]   k;

  assign k = imm[SHW-1:0];

  // The one adder serves ALU ops when idle and the accumulate step while multiplying.
  always_comb begin
    as_a   = a_in;
    as_b   = b_in;
    as_cin = 1'b0;
    as_sub = 1'b0;
    if (state == ST_MUL) begin
      as_a = acc;
      as_b = mcand;
    end else begin
      case (op)
        OP_ADC: as_cin = c;
        OP_SUB, OP_CMP: as_sub = 1'b1;
        OP_SBB: begin
          as_sub = 1'b1;
          as_cin = c;
        end
        OP_INC: as_b = WIDTH'(imm);
        default: ;
      endcase
    end
  end

  s_alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a(as_a), .b(as_b), .cin(as_cin), .sub(as_sub),
    .sum(as_sum), .cout(as_co), .ovf(as_ov)
  );

  always_comb begin
    lg_res = a_in & b_in;
    case (op)
      OP_OR:  lg_res = a_in | b_in;
      OP_XOR: lg_res = a_in ^ b_in;
      default: ;
    endcase
  end

  always_comb begin
    case (sh_op)
      OP_SHL:  {sh_out, sh_next} = {sh_q, 1'b0};
      OP_SHR:  {sh_next, sh_out} = {1'b0, sh_q};
      default: {sh_next, sh_out} = {sh_q[WIDTH-1], sh_q};
    endcase
  end

  // One shift-add step: {acc,mplr} shifts right, adding the multiplicand first when mplr[0] is set.
  always_comb begin
    acc_next  = {1'b0, acc[WIDTH-1:1]};
    mplr_next = {acc[0], mplr[WIDTH-1:1]};
    if (mplr[0]) begin
      acc_next  = {as_co, as_sum[WIDTH-1:1]};
      mplr_next = {as_sum[0], mplr[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      sh_op <= OP_SHL;
      cnt   <= '0;
      sh_q  <= '0;
      mcand <= '0;
      acc   <= '0;
      mplr  <= '0;
      a_out <= '0;
      b_out <= '0;
      {z, n, c, v} <= 4'b0000;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          done <= 1'b1;
          case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_INC, OP_CMP: begin
              if (op != OP_CMP) a_out <= as_sum;
              z <= (as_sum == '0);
              n <= as_sum[WIDTH-1];
              c <= as_co;
              v <= as_ov;
            end
            OP_AND, OP_OR, OP_XOR: begin
              a_out <= lg_res;
              z <= (lg_res == '0);
              n <= lg_res[WIDTH-1];
              c <= 1'b0;
              v <= 1'b0;
            end
            OP_SHL, OP_SHR, OP_ASR: begin
              if (k == '0) begin
                a_out <= a_in;
                z <= (a_in == '0);
                n <= a_in[WIDTH-1];
              end else begin
                sh_q  <= a_in;
                sh_op <= op;
                cnt   <= {1'b0, k};
                state <= ST_SHIFT;
                busy  <= 1'b1;
                done  <= 1'b0;
              end
            end
            OP_MUL: begin
              mcand <= a_in;
              mplr  <= b_in;
              acc   <= '0;
              cnt   <= CNT_MUL;
              state <= ST_MUL;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
            OP_MOV: b_out <= a_in;
            OP_EXCH: begin
              a_out <= b_in;
              b_out <= a_in;
            end
            OP_FLG: begin
              if (imm[FLAG_Z]) z <= !imm[FLAG_CLR];
              if (imm[FLAG_N]) n <= !imm[FLAG_CLR];
              if (imm[FLAG_C]) c <= !imm[FLAG_CLR];
              if (imm[FLAG_V]) v <= !imm[FLAG_CLR];
            end
            default: ;
          endcase
        end
        ST_SHIFT: begin
          sh_q <= sh_next;
          cnt  <= cnt - 1'b1;
          if (cnt == CNT_LAST) begin
            a_out <= sh_next;
            z     <= (sh_next == '0);
            n     <= sh_next[WIDTH-1];
            c     <= sh_out;
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_MUL: begin
          acc  <= acc_next;
          mplr <= mplr_next;
          cnt  <= cnt - 1'b1;
          if (cnt == CNT_LAST) begin
            a_out <= mplr_next;
            b_out <= acc_next;
            z     <= (acc_next == '0) && (mplr_next == '0);
            n     <= acc_next[WIDTH-1];
            c     <= |acc_next;
            v     <= |acc_next;
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
